// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaler.
// A run/pause/expire FSM controls the count. It raises a one-cycle done pulse
// when the count reaches zero while running.
module countdown_timer #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state
);

   localparam int unsigned     PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_RUN     = 2'b01;
   localparam logic [1:0] ST_PAUSE   = 2'b10;
   localparam logic [1:0] ST_EXPIRED = 2'b11;

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [1:0]       state_q, state_d;
   logic             done_q,  done_d;
   logic             busy_q,  busy_d;
   logic             tick;

   // Tick when the prescaler has completed its period; PRESCALE=1 ticks every RUN cycle
   assign tick = (PRESCALE == 1) ? 1'b1 : (presc_q == PRESC_LAST);

   // State register with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         presc_q <= '0;
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         state_q <= state_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic: load has priority over FSM transitions
   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      state_d = state_q;
      done_d  = 1'b0;

      if (load) begin
         count_d = load_value;
         presc_d = '0;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && (count_q != '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!enable) begin
                  // Pause without taking a tick; prescaler phase is kept
                  state_d = ST_PAUSE;
               end else if (tick) begin
                  count_d = count_q - WIDTH'(1);
                  presc_d = '0;
                  if (count_q == WIDTH'(1)) begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (enable) state_d = ST_RUN;
            end
            default: begin
               // Expired: hold at zero until load or reset
            end
         endcase
      end

      busy_d = (state_d == ST_RUN);
   end

   assign count = count_q;
   assign zero  = (count_q == '0);
   assign done  = done_q;
   assign busy  = busy_q;
   assign state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: PRESCALE=1 and PRESCALE=4 instances share stimulus
// and are compared every cycle against a remaining-cycles reference model.
module tb_countdown_timer;

   localparam int unsigned WIDTH = 16;

   logic             clock = 1'b0;
   logic             reset, load, enable;
   logic [WIDTH-1:0] load_value;

   logic [WIDTH-1:0] count_p1, count_p4;
   logic             zero_p1, zero_p4, done_p1, done_p4, busy_p1, busy_p4;
   logic [1:0]       state_p1, state_p4;

   countdown_timer #(.WIDTH(WIDTH), .PRESCALE(1)) u_dut_p1 (
      .clock(clock), .reset(reset), .load(load), .load_value(load_value), .enable(enable),
      .count(count_p1), .zero(zero_p1), .done(done_p1), .busy(busy_p1), .state(state_p1)
   );

   countdown_timer #(.WIDTH(WIDTH), .PRESCALE(4)) u_dut_p4 (
      .clock(clock), .reset(reset), .load(load), .load_value(load_value), .enable(enable),
      .count(count_p4), .zero(zero_p4), .done(done_p4), .busy(busy_p4), .state(state_p4)
   );

   always #5 clock = ~clock;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model: remaining RUN cycles until zero; count = ceil(rem / P)
   int     psc[2] = '{1, 4};
   longint rem_m[2];
   int     mode_m[2];     // 0 idle, 1 run, 2 pause, 3 expired
   bit     done_m[2];
   int     done_seen[2];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         done_m[i] = 1'b0;
         if (reset) begin
            rem_m[i]  = 0;
            mode_m[i] = 0;
         end else if (load) begin
            rem_m[i]  = longint'(load_value) * psc[i];
            mode_m[i] = 0;
         end else begin
            case (mode_m[i])
               0: if (enable && rem_m[i] != 0) mode_m[i] = 1;
               1: begin
                  if (!enable) mode_m[i] = 2;
                  else begin
                     rem_m[i]--;
                     if (rem_m[i] == 0) begin
                        mode_m[i] = 3;
                        done_m[i] = 1'b1;
                     end
                  end
               end
               2: if (enable) mode_m[i] = 1;
               default: ;
            endcase
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         logic [WIDTH-1:0] c;
         logic             z, d, b;
         logic [1:0]       s;
         longint           exp_cnt;
         c = (i == 0) ? count_p1 : count_p4;
         z = (i == 0) ? zero_p1  : zero_p4;
         d = (i == 0) ? done_p1  : done_p4;
         b = (i == 0) ? busy_p1  : busy_p4;
         s = (i == 0) ? state_p1 : state_p4;
         exp_cnt = (rem_m[i] + psc[i] - 1) / psc[i];
         check_eq($sformatf("p%0d count", psc[i]), 64'(c), 64'(exp_cnt));
         check_eq($sformatf("p%0d zero",  psc[i]), 64'(z), 64'(rem_m[i] == 0));
         check_eq($sformatf("p%0d done",  psc[i]), 64'(d), 64'(done_m[i]));
         check_eq($sformatf("p%0d busy",  psc[i]), 64'(b), 64'(mode_m[i] == 1));
         check_eq($sformatf("p%0d state", psc[i]), 64'(s), 64'(mode_m[i]));
         if (d === 1'b1) done_seen[i]++;
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v);
      load = 1'b1;
      load_value = v;
      step();
      load = 1'b0;
   endtask

   initial begin
      int lat;
      reset = 1'b1; load = 1'b0; enable = 1'b1; load_value = '0;
      for (int i = 0; i < 2; i++) begin
         rem_m[i] = 0; mode_m[i] = 0; done_m[i] = 1'b0; done_seen[i] = 0;
      end

      // Reset held two cycles with enable high
      step(); step();
      check_eq("reset count", 64'(count_p1), 64'd0);
      check_eq("reset zero",  64'(zero_p4),  64'd1);

      // Load 5 and run to expiry, then hold at zero
      reset = 1'b0;
      enable = 1'b0;
      do_load(16'd5);
      enable = 1'b1;
      done_seen[0] = 0; done_seen[1] = 0;
      repeat (30) step();
      check_eq("p1 done pulses", 64'(done_seen[0]), 64'd1);
      check_eq("p4 done pulses", 64'(done_seen[1]), 64'd1);
      check_eq("p1 expired hold", 64'(count_p1), 64'd0);

      // PRESCALE=4 latency from RUN entry to done for load 3
      enable = 1'b0;
      do_load(16'd3);
      enable = 1'b1;
      step();
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (done_p4 === 1'b1) begin
            lat = k;
            break;
         end
      end
      check_eq("p4 latency", 64'(lat), 64'd12);
      repeat (5) step();

      // Pause mid-prescale at count 7 and resume
      enable = 1'b0;
      do_load(16'd10);
      enable = 1'b1;
      step();
      repeat (14) step();
      enable = 1'b0;
      repeat (20) step();
      check_eq("pause count", 64'(count_p4), 64'd7);
      check_eq("pause state", 64'(state_p4), 64'd2);
      enable = 1'b1;
      step(); step();
      check_eq("resume hold", 64'(count_p4), 64'd7);
      step();
      check_eq("resume tick", 64'(count_p4), 64'd6);
      repeat (30) step();

      // Load on a tick edge of the PRESCALE=4 instance wins
      enable = 1'b0;
      do_load(16'd9);
      enable = 1'b1;
      step();
      repeat (3) step();
      do_load(16'h00FF);
      check_eq("load on tick count", 64'(count_p4), 64'h00FF);
      check_eq("load on tick state", 64'(state_p4), 64'd0);

      // Load 0 with enable high stays idle and never pulses done
      do_load(16'd0);
      done_seen[0] = 0; done_seen[1] = 0;
      repeat (10) step();
      check_eq("load0 done p1", 64'(done_seen[0]), 64'd0);
      check_eq("load0 done p4", 64'(done_seen[1]), 64'd0);
      check_eq("load0 state", 64'(state_p1), 64'd0);

      // Reset in the middle of a long run
      do_load(16'hFFFF);
      repeat (100) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("midrun reset count", 64'(count_p4), 64'd0);
      check_eq("midrun reset state", 64'(state_p1), 64'd0);
      check_eq("midrun reset done",  64'(done_p1),  64'd0);
      step();

      // Randomized traffic
      for (int k = 0; k < 4000; k++) begin
         reset  = ($urandom_range(0, 199) == 0);
         load   = ($urandom_range(0, 19) == 0);
         enable = ($urandom_range(0, 9) < 8);
         load_value = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
